vga_blitter: RTL and testbench
==============================

VGA_BLITTER -- requirements
Module: vga_blitter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, bus byte-address width.
REQ-002 SHALL have parameter LEN_W, default 16, word-count width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max cycles waiting for ready per transaction.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all logic rising-edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-009 cmd_op  in  1  0=fill, 1=copy.
REQ-010 cmd_src  in  ADDR_W  copy source byte address, word aligned.
REQ-011 cmd_dst  in  ADDR_W  destination byte address, word aligned.
REQ-012 cmd_len  in  LEN_W  number of 32-bit words.
REQ-013 cmd_fill  in  32  fill pattern.
REQ-014 busy  out  1  command in progress.
REQ-015 done  out  1  one-cycle pulse, command finished OK.
REQ-016 err  out  1  one-cycle pulse, command aborted on timeout.
REQ-017 sel  out  1  bus transaction request (initiator side of VGA MMIO bus).
REQ-018 wstrb  out  4  byte strobes; 0 = read, 4'hF = write.
REQ-019 addr  out  ADDR_W  bus byte address.
REQ-020 wdata  out  32  write data.
REQ-021 rdata  in  32  read data, valid in ready cycle.
REQ-022 ready  in  1  responder completes current transaction.

Function
REQ-023 States SHALL be IDLE, RD, WR, GAP; cmd_ready=1 only in IDLE.
REQ-024 On accept: latch src/dst/len/op/fill; len=0 -> done pulse next cycle, no bus traffic, stay IDLE.
REQ-025 Accept with len>0: next state RD (copy) or WR (fill); sel rises the cycle after accept.
REQ-026 RD: sel=1, wstrb=0, addr=src; on ready capture rdata into buffer, go GAP.
REQ-027 WR: sel=1, wstrb=4'hF, addr=dst, wdata=fill (fill) or buffer (copy); on ready go GAP.
REQ-028 sel, addr, wstrb, wdata SHALL be stable while waiting for ready.
REQ-029 GAP: sel=0 exactly one cycle (responder clears read-ready only on !sel); mandatory between every transaction.
REQ-030 After each write: src+=4 and dst+=4 modulo 2^ADDR_W (wrap silently); remaining count -=1.
REQ-031 From GAP: remaining>0 -> RD/WR per op; remaining=0 -> done pulse in that GAP cycle, then IDLE.
REQ-032 Timeout counter resets on entering RD/WR; reaching TIMEOUT without ready -> sel=0, err pulse, IDLE, remainder discarded.
REQ-033 ready while sel=0 SHALL be ignored.
REQ-034 done and err SHALL never assert in the same cycle.
REQ-035 busy=1 from accept cycle+1 until the cycle done/err is asserted inclusive.

Reset
REQ-036 Reset SHALL force IDLE; sel=0, wstrb=0, addr=0, wdata=0, busy=0, done=0, err=0, cmd_ready=1.
REQ-037 Reset mid-transaction SHALL drop sel immediately (asynchronously) and discard the command.

Structure
REQ-038 Package vga_blitter_pkg SHALL hold state enum, OP_FILL/OP_COPY, WSTRB_RD=4'h0, WSTRB_WR=4'hF.
REQ-039 One sub-module vga_bus_xfer (single transaction + GAP + timeout) is natural; sequencing stays in vga_blitter.

Verification
REQ-040 Fill dst=0x000100 len=3 fill=0x0741_0741, ready after 1 cycle -> writes to 0x100,0x104,0x108, sel low between each, one done.
REQ-041 Copy src=0x020000 dst=0x000000 len=2, responder rdata 0xDEADBEEF,0x12345678 -> writes same data to 0x0,0x4 in order.
REQ-042 len=0 -> done pulse 1 cycle after accept, sel never high.
REQ-043 TIMEOUT=8, ready never asserted -> err after 8 cycles of sel, done never, back to IDLE with cmd_ready=1.
REQ-044 Fill dst=0xFFFFFC len=2 -> writes 0xFFFFFC then 0x000000.
REQ-045 Reset asserted during WR of copy len=4 -> sel=0 same cycle, busy=0, next command executes normally.

Source files
------------

// File: rtl/vga_blitter_pkg.sv
// Shared types and constants for the VGA MMIO fill/copy blitter.
package vga_blitter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic       OP_FILL    = 1'b0;
  localparam logic       OP_COPY    = 1'b1;
  localparam logic [3:0] WSTRB_RD   = 4'h0;
  localparam logic [3:0] WSTRB_WR   = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/vga_bus_xfer.sv
// Per-transaction watchdog for the VGA MMIO bus: qualifies ready with sel
// and flags a transaction that has waited TIMEOUT cycles without ready.
module vga_bus_xfer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_i,
  input  logic ready_i,
  output logic ack_o,
  output logic expired_o
);

  // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th waiting cycle is
  // the one whose unanswered end triggers the abort.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Handshake and abort decode for the transaction currently on the bus.
  always_comb begin
    ack_o     = sel_i & ready_i;
    expired_o = sel_i & ~ready_i & (cnt_q == LAST);
  end

  // Wait-cycle count; cleared whenever sel is low so every RD/WR starts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!sel_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_blitter.sv
// Word fill / copy engine acting as initiator on the VGA MMIO bus.
// Every bus transaction is followed by a one-cycle GAP with sel low.
module vga_blitter
  import vga_blitter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_fill,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sel,
  output logic [3:0]        wstrb,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              ready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                op_q, op_d;
  logic [31:0]         fill_q, fill_d;
  logic [31:0]         buf_q, buf_d;
  logic                have_q, have_d;
  logic                zdone_q, zdone_d;
  logic                err_q, err_d;
  logic                gap_done;
  logic                ack;
  logic                expired;

  vga_bus_xfer #(
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clk       (clk),
    .reset     (reset),
    .sel_i     (sel),
    .ready_i   (ready),
    .ack_o     (ack),
    .expired_o (expired)
  );

  // Bus-facing outputs decode straight from registered state so they stay
  // stable while waiting and drop together with the asynchronous reset.
  always_comb begin
    sel       = (state_q == RD) || (state_q == WR);
    wstrb     = (state_q == WR) ? WSTRB_WR : WSTRB_RD;
    addr      = '0;
    wdata     = '0;
    if (state_q == RD) begin
      addr = src_q;
    end else if (state_q == WR) begin
      addr  = dst_q;
      wdata = (op_q == OP_FILL) ? fill_q : buf_q;
    end
    cmd_ready = (state_q == IDLE);
    done      = zdone_q || gap_done;
    err       = err_q;
    busy      = (state_q != IDLE) || zdone_q || err_q;
  end

  // Command sequencing: accept, alternate RD/WR with GAPs, count words down.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    op_d     = op_q;
    fill_d   = fill_q;
    buf_d    = buf_q;
    have_d   = have_q;
    zdone_d  = 1'b0;
    err_d    = 1'b0;
    gap_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          rem_d  = cmd_len;
          op_d   = cmd_op;
          fill_d = cmd_fill;
          have_d = 1'b0;
          if (cmd_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = (cmd_op == OP_COPY) ? RD : WR;
          end
        end
      end
      RD: begin
        if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ack) begin
          buf_d   = rdata;
          have_d  = 1'b1;
          state_d = GAP;
        end
      end
      WR: begin
        if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ack) begin
          src_d   = src_q + ADDR_W'(WORD_BYTES);
          dst_d   = dst_q + ADDR_W'(WORD_BYTES);
          rem_d   = rem_q - 1'b1;
          have_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (rem_q == '0) begin
          gap_done = 1'b1;
          state_d  = IDLE;
        end else if ((op_q == OP_COPY) && !have_q) begin
          state_d = RD;
        end else begin
          state_d = WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_FILL;
      fill_q  <= '0;
      buf_q   <= '0;
      have_q  <= 1'b0;
      zdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      have_q  <= have_d;
      zdone_q <= zdone_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_blitter.sv
// Self-checking bench for vga_blitter: command table, bus responder,
// write scoreboard, and hand sequences for timeout and mid-command reset.
module tb_vga_blitter;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [23:0] cmd_src;
  logic [23:0] cmd_dst;
  logic [15:0] cmd_len;
  logic [31:0] cmd_fill;
  logic        busy;
  logic        done;
  logic        err;
  logic        sel;
  logic [3:0]  wstrb;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  vga_blitter #(
    .ADDR_W  (24),
    .LEN_W   (16),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_fill  (cmd_fill),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sel       (sel),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        op;
    logic [23:0] src;
    logic [23:0] dst;
    logic [15:0] len;
    logic [31:0] fill;
    int          lat;
    int          exp_writes;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t  exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;
  int   n_err = 0;
  int   n_wr = 0;
  int   n_selcyc = 0;
  int   run = 0;
  int   last_run = 0;
  int   resp_lat = 1;
  bit   prev_hs = 1'b0;
  logic [23:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input logic [23:0] a);
    case (a)
      24'h020000: pat = 32'hDEADBEEF;
      24'h020004: pat = 32'h12345678;
      default:    pat = {8'hC0, a};
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus responder plus write scoreboard and pulse monitor, all on negedge.
  initial begin
    ready = 1'b0;
    rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (prev_hs) chk("gap_sel_low", 64'(sel), 64'd0);
      prev_hs = 1'b0;
      if (done || err) chk("done_err_exclusive", 64'(done && err), 64'd0);
      if (done) n_done++;
      if (err) n_err++;
      if (reset || !sel) begin
        if (run > 0) last_run = run;
        run   = 0;
        ready = 1'b0;
        rdata = 32'hBAD0BAD0;
      end else begin
        n_selcyc++;
        run++;
        if (run == 1) begin
          hold_addr  = addr;
          hold_wdata = wdata;
          hold_wstrb = wstrb;
        end else begin
          chk("stable_addr", 64'(addr), 64'(hold_addr));
          chk("stable_wdata", 64'(wdata), 64'(hold_wdata));
          chk("stable_wstrb", 64'(wstrb), 64'(hold_wstrb));
        end
        if (run > resp_lat) begin
          ready   = 1'b1;
          rdata   = pat(addr);
          prev_hs = 1'b1;
          if (wstrb == 4'hF) begin
            n_wr++;
            if (exp_q.size() == 0) begin
              chk("write_expected", 64'(exp_q.size()), 64'd1);
            end else begin
              wr_t e;
              e = exp_q.pop_front();
              chk("wr_addr", 64'(addr), 64'(e.a));
              chk("wr_data", 64'(wdata), 64'(e.d));
            end
          end else begin
            chk("rd_wstrb", 64'(wstrb), 64'd0);
          end
        end else begin
          ready = 1'b0;
          rdata = 32'hBAD0BAD0;
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    for (int i = 0; i < v.exp_writes; i++) begin
      wr_t e;
      logic [23:0] sa;
      e.a = v.dst + 24'(4 * i);
      sa  = v.src + 24'(4 * i);
      e.d = v.op ? pat(sa) : v.fill;
      exp_q.push_back(e);
    end
    resp_lat = v.lat;
    @(negedge clk);
    #1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_op    = v.op;
    cmd_src   = v.src;
    cmd_dst   = v.dst;
    cmd_len   = v.len;
    cmd_fill  = v.fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("sel_after_accept", 64'(sel), 64'(v.len != 16'd0));
    if (v.len == 16'd0) chk("len0_done_next_cycle", 64'(done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, w0, s0;
    bit fin;
    d0 = n_done;
    e0 = n_err;
    w0 = n_wr;
    s0 = n_selcyc;
    issue(v);
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk);
      if (n_done != d0 || n_err != e0) fin = 1'b1;
    end
    chk("cmd_finished", 64'(fin), 64'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("done_count", 64'(n_done - d0), 64'(v.exp_done));
    chk("err_count", 64'(n_err - e0), 64'(v.exp_err));
    chk("write_count", 64'(n_wr - w0), 64'(v.exp_writes));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    if (v.len == 16'd0) chk("len0_no_sel", 64'(n_selcyc - s0), 64'd0);
    if (v.exp_err) chk("timeout_sel_cycles", 64'(last_run), 64'(TMO));
    exp_q.delete();
  endtask

  vec_t vt[8];
  vec_t vr;
  vec_t vp;

  initial begin
    bit found;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_fill  = '0;
    #1;
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vt[0] = '{1'b0, 24'h000000, 24'h000100, 16'd3, 32'h07410741, 1, 3, 1'b1, 1'b0};
    vt[1] = '{1'b1, 24'h020000, 24'h000000, 16'd2, 32'h0, 1, 2, 1'b1, 1'b0};
    vt[2] = '{1'b0, 24'h000000, 24'h000040, 16'd0, 32'h11111111, 1, 0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 24'h000000, 24'hFFFFFC, 16'd2, 32'hA5A5A5A5, 0, 2, 1'b1, 1'b0};
    vt[4] = '{1'b1, 24'hFFFFF8, 24'h000400, 16'd3, 32'h0, 3, 3, 1'b1, 1'b0};
    vt[5] = '{1'b0, 24'h000000, 24'h000800, 16'd1, 32'hCAFEF00D, 7, 1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 24'h010000, 24'h000900, 16'd2, 32'h0, 8, 0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 24'h000000, 24'h000200, 16'd3, 32'h55AA55AA, 1000, 0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Reset while a copy is in its write phase; command must be dropped.
    vr = '{1'b1, 24'h030000, 24'h000800, 16'd4, 32'h0, 2, 4, 1'b0, 1'b0};
    issue(vr);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      #1;
      if (sel && wstrb == 4'hF) found = 1'b1;
    end
    chk("reset_seq_reached_wr", 64'(found), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_sel", 64'(sel), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_addr", 64'(addr), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    vp = '{1'b0, 24'h000000, 24'h000300, 16'd2, 32'h0F0F0F0F, 2, 2, 1'b1, 1'b0};
    run_vec(vp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
